// File: rtl/inst_mem_arbiter.sv
// Round-robin arbiter sharing one instruction memory port among per-core L1 I-caches.
// The grant is held for a whole line fill so beats from different cores never interleave.
module inst_mem_arbiter #(
    parameter int unsigned NUM_PORTS      = 2,
    parameter int unsigned BEATS_PER_LINE = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_PORTS-1:0]    port_req,
    input  logic [32*NUM_PORTS-1:0] port_addr,
    output logic [31:0]             port_rdata,
    output logic [NUM_PORTS-1:0]    port_ready,
    output logic                    mem_req,
    output logic [31:0]             mem_addr,
    input  logic [31:0]             mem_rdata,
    input  logic                    mem_ready,
    output logic                    grant_valid,
    output logic [1:0]              grant_id
);
    localparam int unsigned MAX_PORTS = 4;
    localparam int unsigned ID_W      = 2;
    localparam int unsigned BEAT_W    = (BEATS_PER_LINE > 1) ? $clog2(BEATS_PER_LINE) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS_PER_LINE - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t            state;
    logic [ID_W-1:0]   owner;
    logic [BEAT_W-1:0] beat_cnt;
    logic [ID_W-1:0]   rr_ptr;

    // Ports widened to the architectural maximum so a 2-bit owner index is always in range
    logic [MAX_PORTS-1:0] req_ext;
    logic [31:0]          addr_ext [MAX_PORTS];

    assign req_ext = MAX_PORTS'(port_req);

    for (genvar g = 0; g < MAX_PORTS; g++) begin : g_addr
        if (g < NUM_PORTS) begin : g_used
            assign addr_ext[g] = port_addr[32*g +: 32];
        end else begin : g_unused
            assign addr_ext[g] = '0;
        end
    end

    logic            owner_req;
    logic [ID_W-1:0] next_ptr;

    assign owner_req = req_ext[owner];
    assign next_ptr  = ID_W'((32'(owner) + 32'd1) % NUM_PORTS);

    // First requester found scanning upward from rr_ptr, wrapping modulo NUM_PORTS
    logic            pick_found;
    logic [ID_W-1:0] pick_id;
    logic [ID_W-1:0] scan_id;

    always_comb begin
        pick_found = 1'b0;
        pick_id    = '0;
        scan_id    = '0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            scan_id = ID_W'((32'(rr_ptr) + i) % NUM_PORTS);
            if (!pick_found && req_ext[scan_id]) begin
                pick_found = 1'b1;
                pick_id    = scan_id;
            end
        end
    end

    // Control state: arbitration in IDLE, beat counting and release in GRANT
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            owner    <= '0;
            beat_cnt <= '0;
            rr_ptr   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        owner    <= pick_id;
                        beat_cnt <= '0;
                        state    <= GRANT;
                    end
                end
                GRANT: begin
                    if (!owner_req) begin
                        // Owner abandoned the line; a ready without a request is ignored
                        rr_ptr   <= next_ptr;
                        beat_cnt <= '0;
                        state    <= IDLE;
                    end else if (mem_ready) begin
                        if (beat_cnt == LAST_BEAT) begin
                            rr_ptr   <= next_ptr;
                            beat_cnt <= '0;
                            state    <= IDLE;
                        end else begin
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Memory-side and cache-side outputs; zero outside GRANT to keep X out of the memory model
    always_comb begin
        mem_req     = 1'b0;
        mem_addr    = '0;
        port_rdata  = '0;
        grant_valid = 1'b0;
        grant_id    = '0;
        port_ready  = '0;
        if (state == GRANT) begin
            mem_req     = owner_req;
            mem_addr    = addr_ext[owner];
            port_rdata  = mem_rdata;
            grant_valid = 1'b1;
            grant_id    = owner;
            for (int unsigned i = 0; i < NUM_PORTS; i++) begin
                port_ready[i] = (owner == ID_W'(i)) && owner_req && mem_ready;
            end
        end
    end

    a_ready_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(port_ready));
    a_ready_needs_req: assert property (@(posedge clk) disable iff (rst) (|port_ready) |-> mem_req);
    a_idle_id_zero: assert property (@(posedge clk) disable iff (rst) !grant_valid |-> (grant_id == '0));

endmodule

// File: tb/tb_inst_mem_arbiter.sv
// Directed bench for inst_mem_arbiter: behavioural caches and memory, per-cycle trace, inline checks.
module tb_inst_mem_arbiter;
    localparam int NP   = 2;
    localparam int BPL  = 4;
    localparam int MAXC = 64;

    logic              clk = 1'b0;
    logic              rst;
    logic [NP-1:0]     port_req;
    logic [32*NP-1:0]  port_addr;
    logic [31:0]       port_rdata;
    logic [NP-1:0]     port_ready;
    logic              mem_req;
    logic [31:0]       mem_addr;
    logic [31:0]       mem_rdata;
    logic              mem_ready;
    logic              grant_valid;
    logic [1:0]        grant_id;

    int tests_run    = 0;
    int tests_failed = 0;

    inst_mem_arbiter #(.NUM_PORTS(NP), .BEATS_PER_LINE(BPL)) dut (
        .clk        (clk),
        .rst        (rst),
        .port_req   (port_req),
        .port_addr  (port_addr),
        .port_rdata (port_rdata),
        .port_ready (port_ready),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready),
        .grant_valid(grant_valid),
        .grant_id   (grant_id)
    );

    always #5 clk = ~clk;

    // Cache model state and memory mode (0 zero-wait, 1 three wait states, 2 ready stuck high)
    logic        c_active [NP];
    logic [31:0] c_addr   [NP];
    int          c_beats  [NP];
    int          c_lines  [NP];
    int          c_drop   [NP];
    logic [NP-1:0] seen_ready;
    int          mem_mode;
    int          wcnt;

    logic          t_gv    [MAXC];
    logic [1:0]    t_gid   [MAXC];
    logic [NP-1:0] t_pr    [MAXC];
    logic [31:0]   t_rdata [MAXC];
    logic          t_mreq  [MAXC];
    logic [31:0]   t_maddr [MAXC];
    logic [1:0]    t_beat  [MAXC];
    logic [1:0]    t_rr    [MAXC];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0000;
    endfunction

    task automatic drive_ports();
        for (int p = 0; p < NP; p++) begin
            port_req[p]           = c_active[p];
            port_addr[32*p +: 32] = c_addr[p];
        end
    endtask

    task automatic mem_model();
        case (mem_mode)
            0: mem_ready = mem_req;
            1: begin
                if (mem_req) begin
                    if (wcnt == 3) begin
                        mem_ready = 1'b1;
                        wcnt      = 0;
                    end else begin
                        mem_ready = 1'b0;
                        wcnt++;
                    end
                end else begin
                    mem_ready = 1'b0;
                    wcnt      = 0;
                end
            end
            default: mem_ready = 1'b1;
        endcase
        mem_rdata = mem_ready ? mem_word(mem_addr) : 32'hDEAD_BEEF;
    endtask

    // One clock: caches react to last cycle's ready, memory reacts, outputs sampled at negedge
    task automatic cycle(input int k);
        @(posedge clk);
        #1;
        for (int p = 0; p < NP; p++) begin
            if (seen_ready[p]) begin
                c_addr[p] = c_addr[p] + 32'd4;
                c_beats[p]++;
                if (c_beats[p] == BPL) begin
                    c_beats[p] = 0;
                    c_lines[p]--;
                    if (c_lines[p] <= 0) c_active[p] = 1'b0;
                end
                if (c_drop[p] != 0 && c_beats[p] == c_drop[p]) begin
                    c_active[p] = 1'b0;
                    c_drop[p]   = 0;
                end
            end
        end
        drive_ports();
        #1;
        mem_model();
        @(negedge clk);
        t_gv[k]    = grant_valid;
        t_gid[k]   = grant_id;
        t_pr[k]    = port_ready;
        t_rdata[k] = port_rdata;
        t_mreq[k]  = mem_req;
        t_maddr[k] = mem_addr;
        t_beat[k]  = dut.beat_cnt;
        t_rr[k]    = dut.rr_ptr;
        seen_ready = port_ready;
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) cycle(k);
    endtask

    task automatic clear_model();
        for (int p = 0; p < NP; p++) begin
            c_active[p] = 1'b0;
            c_addr[p]   = '0;
            c_beats[p]  = 0;
            c_lines[p]  = 0;
            c_drop[p]   = 0;
        end
        seen_ready = '0;
        mem_mode   = 0;
        wcnt       = 0;
        drive_ports();
        mem_ready  = 1'b0;
        mem_rdata  = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_model();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        clear_model();
        port_req  = '1;
        mem_ready = 1'b1;
        mem_rdata = 32'h1234_5678;
        @(posedge clk);
        #2;
        tests_run++;
        if ({mem_req, mem_addr, port_rdata, port_ready, grant_valid, grant_id} !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs: mem_req=%b mem_addr=%h rdata=%h ready=%b gv=%b gid=%0d, required all zero",
                     mem_req, mem_addr, port_rdata, port_ready, grant_valid, grant_id);
        end
        do_reset();
        mem_mode = 2;
        run(3);
        for (int k = 0; k < 3; k++) begin
            tests_run++;
            if (t_pr[k] !== '0 || t_mreq[k] !== 1'b0 || t_gv[k] !== 1'b0 || t_beat[k] !== 2'd0 ||
                t_rdata[k] !== '0 || t_maddr[k] !== '0) begin
                tests_failed++;
                $display("FAIL idle_stray_ready%0d: ready=%b mem_req=%b gv=%b beat=%0d rdata=%h addr=%h, required all zero",
                         k, t_pr[k], t_mreq[k], t_gv[k], t_beat[k], t_rdata[k], t_maddr[k]);
            end
        end
    endtask

    task automatic test_single_port();
        logic [31:0] ea;
        do_reset();
        c_active[0] = 1'b1;
        c_addr[0]   = 32'h100;
        c_lines[0]  = 1;
        run(6);
        tests_run++;
        if (t_mreq[0] !== 1'b0 || t_gv[0] !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_latency: mem_req=%b gv=%b in request cycle, required 0 0", t_mreq[0], t_gv[0]);
        end
        for (int b = 0; b < 4; b++) begin
            ea = 32'h100 + 32'(4 * b);
            tests_run++;
            if (t_mreq[b+1] !== 1'b1 || t_gv[b+1] !== 1'b1 || t_gid[b+1] !== 2'd0 || t_pr[b+1] !== 2'b01 ||
                t_maddr[b+1] !== ea || t_rdata[b+1] !== mem_word(ea)) begin
                tests_failed++;
                $display("FAIL single_beat%0d: mem_req=%b gv=%b gid=%0d ready=%b addr=%h rdata=%h, required 1 1 0 01 %h %h",
                         b, t_mreq[b+1], t_gv[b+1], t_gid[b+1], t_pr[b+1], t_maddr[b+1], t_rdata[b+1], ea, mem_word(ea));
            end
        end
        tests_run++;
        if (t_gv[5] !== 1'b0 || t_mreq[5] !== 1'b0 || t_pr[5] !== 2'b00 || t_rr[5] !== 2'd1) begin
            tests_failed++;
            $display("FAIL single_release: gv=%b mem_req=%b ready=%b rr_ptr=%0d, required 0 0 00 1",
                     t_gv[5], t_mreq[5], t_pr[5], t_rr[5]);
        end
    endtask

    task automatic test_simultaneous();
        logic [31:0] ea;
        int          k;
        do_reset();
        c_active[0] = 1'b1; c_addr[0] = 32'h100; c_lines[0] = 1;
        c_active[1] = 1'b1; c_addr[1] = 32'h200; c_lines[1] = 1;
        run(11);
        for (int p = 0; p < 2; p++) begin
            for (int b = 0; b < 4; b++) begin
                k  = 1 + 5 * p + b;
                ea = (p == 0 ? 32'h100 : 32'h200) + 32'(4 * b);
                tests_run++;
                if (t_gid[k] !== 2'(p) || t_pr[k] !== (p == 0 ? 2'b01 : 2'b10) || t_maddr[k] !== ea ||
                    t_rdata[k] !== mem_word(ea)) begin
                    tests_failed++;
                    $display("FAIL simul_p%0d_beat%0d: gid=%0d ready=%b addr=%h rdata=%h, required gid=%0d addr=%h rdata=%h",
                             p, b, t_gid[k], t_pr[k], t_maddr[k], t_rdata[k], p, ea, mem_word(ea));
                end
            end
        end
        tests_run++;
        if (t_gv[5] !== 1'b0 || t_gv[10] !== 1'b0) begin
            tests_failed++;
            $display("FAIL simul_idle_gap: gv@5=%b gv@10=%b, required 0 0", t_gv[5], t_gv[10]);
        end
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_gid [4];
        exp_gid = '{2'd0, 2'd1, 2'd0, 2'd1};
        do_reset();
        c_active[0] = 1'b1; c_addr[0] = 32'h100; c_lines[0] = 2;
        c_active[1] = 1'b1; c_addr[1] = 32'h200; c_lines[1] = 2;
        run(21);
        for (int l = 0; l < 4; l++) begin
            tests_run++;
            if (t_gv[1 + 5*l] !== 1'b1 || t_gid[1 + 5*l] !== exp_gid[l] || t_gv[5 + 5*l] !== 1'b0) begin
                tests_failed++;
                $display("FAIL rr_line%0d: gv=%b gid=%0d gap_gv=%b, required 1 %0d 0",
                         l, t_gv[1 + 5*l], t_gid[1 + 5*l], t_gv[5 + 5*l], exp_gid[l]);
            end
        end
        tests_run++;
        if (t_maddr[11] !== 32'h110 || t_maddr[16] !== 32'h210) begin
            tests_failed++;
            $display("FAIL rr_second_line_addr: p0=%h p1=%h, required 00000110 00000210", t_maddr[11], t_maddr[16]);
        end
    endtask

    task automatic test_wait_states();
        logic        rdy;
        logic [31:0] ea;
        do_reset();
        mem_mode    = 1;
        c_active[0] = 1'b1;
        c_addr[0]   = 32'h100;
        c_lines[0]  = 1;
        run(18);
        for (int k = 1; k <= 16; k++) begin
            rdy = (k % 4 == 0);
            ea  = 32'h100 + 32'(4 * ((k - 1) / 4));
            tests_run++;
            if (t_mreq[k] !== 1'b1 || t_pr[k] !== (rdy ? 2'b01 : 2'b00) || t_maddr[k] !== ea ||
                t_beat[k] !== 2'((k - 1) / 4) || (rdy && t_rdata[k] !== mem_word(ea))) begin
                tests_failed++;
                $display("FAIL wait_cycle%0d: mem_req=%b ready=%b addr=%h beat=%0d rdata=%h, required 1 %b %h %0d %h",
                         k, t_mreq[k], t_pr[k], t_maddr[k], t_beat[k], t_rdata[k], rdy, ea, (k - 1) / 4, mem_word(ea));
            end
        end
        tests_run++;
        if (t_gv[17] !== 1'b0) begin
            tests_failed++;
            $display("FAIL wait_release: gv=%b, required 0", t_gv[17]);
        end
    endtask

    task automatic test_abandon();
        do_reset();
        c_active[0] = 1'b1; c_addr[0] = 32'h100; c_lines[0] = 1; c_drop[0] = 2;
        c_active[1] = 1'b1; c_addr[1] = 32'h200; c_lines[1] = 1;
        run(7);
        tests_run++;
        if (t_pr[1] !== 2'b01 || t_pr[2] !== 2'b01) begin
            tests_failed++;
            $display("FAIL abandon_beats: ready@1=%b ready@2=%b, required 01 01", t_pr[1], t_pr[2]);
        end
        tests_run++;
        if (t_gv[3] !== 1'b1 || t_mreq[3] !== 1'b0 || t_pr[3] !== 2'b00) begin
            tests_failed++;
            $display("FAIL abandon_drop: gv=%b mem_req=%b ready=%b, required 1 0 00", t_gv[3], t_mreq[3], t_pr[3]);
        end
        tests_run++;
        if (t_gv[4] !== 1'b0 || t_mreq[4] !== 1'b0 || t_rr[4] !== 2'd1) begin
            tests_failed++;
            $display("FAIL abandon_idle: gv=%b mem_req=%b rr_ptr=%0d, required 0 0 1", t_gv[4], t_mreq[4], t_rr[4]);
        end
        tests_run++;
        if (t_gv[5] !== 1'b1 || t_gid[5] !== 2'd1 || t_maddr[5] !== 32'h200 || t_pr[5] !== 2'b10) begin
            tests_failed++;
            $display("FAIL abandon_next_grant: gv=%b gid=%0d addr=%h ready=%b, required 1 1 00000200 10",
                     t_gv[5], t_gid[5], t_maddr[5], t_pr[5]);
        end
    endtask

    task automatic test_reset_midfill();
        do_reset();
        c_active[1] = 1'b1; c_addr[1] = 32'h200; c_lines[1] = 1;
        run(4);
        tests_run++;
        if (t_gid[3] !== 2'd1 || t_pr[3] !== 2'b10 || t_beat[3] !== 2'd2) begin
            tests_failed++;
            $display("FAIL midfill_beat2: gid=%0d ready=%b beat=%0d, required 1 10 2", t_gid[3], t_pr[3], t_beat[3]);
        end
        c_active[0] = 1'b1; c_addr[0] = 32'h100; c_lines[0] = 1;
        drive_ports();
        #1 rst = 1'b1;
        #1;
        tests_run++;
        if ({mem_req, mem_addr, port_rdata, port_ready, grant_valid, grant_id} !== '0 ||
            dut.beat_cnt !== 2'd0 || dut.rr_ptr !== 2'd0) begin
            tests_failed++;
            $display("FAIL midfill_async_reset: mem_req=%b addr=%h rdata=%h ready=%b gv=%b gid=%0d beat=%0d rr=%0d, required all zero",
                     mem_req, mem_addr, port_rdata, port_ready, grant_valid, grant_id, dut.beat_cnt, dut.rr_ptr);
        end
        cycle(4);
        cycle(5);
        rst = 1'b0;
        cycle(6);
        tests_run++;
        if (t_gv[6] !== 1'b1 || t_gid[6] !== 2'd0 || t_maddr[6] !== 32'h100 || t_pr[6] !== 2'b01) begin
            tests_failed++;
            $display("FAIL midfill_restart: gv=%b gid=%0d addr=%h ready=%b, required 1 0 00000100 01",
                     t_gv[6], t_gid[6], t_maddr[6], t_pr[6]);
        end
    endtask

    initial begin
        test_reset();
        test_single_port();
        test_simultaneous();
        test_round_robin();
        test_wait_states();
        test_abandon();
        test_reset_midfill();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/inst_mem_arbiter.md
# inst_mem_arbiter

Multi-port arbiter between the per-core L1 instruction caches and the single shared instruction memory port. Each cache fills a line as a sequence of single-word requests, each held until a one-cycle ready pulse. The arbiter grants one cache at a time with round-robin fairness. It locks the grant for a full line fill so beats from different cores never interleave.

## Interface
Parameters:
- NUM_PORTS, 2, number of requesting caches (2..4)
- BEATS_PER_LINE, 4, word beats per line fill (power of two, 2..8)

Ports:
- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  asynchronous, active-high reset
- port_req  input  NUM_PORTS  per-cache request; held with a stable address until that port's ready
- port_addr  input  32*NUM_PORTS  per-cache word address; port i occupies bits [32*i+31:32*i]
- port_rdata  output  32  read data, broadcast to all ports; meaningful only alongside a port_ready pulse
- port_ready  output  NUM_PORTS  one-hot per-cache ready pulse
- mem_req  output  1  request to instruction memory
- mem_addr  output  32  word address to instruction memory
- mem_rdata  input  32  memory read data; valid when mem_ready=1
- mem_ready  input  1  memory completion pulse for the current request
- grant_valid  output  1  debug: a port currently owns the memory
- grant_id  output  2  debug: owning port index (0 when grant_valid=0)

## Operation
- State: IDLE, GRANT. Registers:
  - owner, 2 bits
  - beat_cnt, log2(BEATS_PER_LINE) bits
  - rr_ptr, 2 bits: highest-priority port for the next arbitration
- IDLE:
  - mem_req=0, port_ready=0.
  - If any port_req is high, select the first requesting port scanning rr_ptr, rr_ptr+1, … (mod NUM_PORTS).
  - Latch that port into owner, clear beat_cnt, go to GRANT.
  - With no requests, stay in IDLE.
- GRANT:
  - mem_req = port_req[owner].
  - mem_addr = port_addr[owner] (combinational mux).
  - port_ready[owner] = mem_ready; all other ready bits are 0.
  - port_rdata = mem_rdata.
- Beat accounting in GRANT, when mem_ready=1:
  - If beat_cnt == BEATS_PER_LINE-1: release. Set rr_ptr = (owner+1) mod NUM_PORTS, clear beat_cnt, go to IDLE.
  - Otherwise: beat_cnt increments and the state stays GRANT.
- Abandon:
  - If port_req[owner]=0 in GRANT with mem_ready=0, release as above, including the rr_ptr advance.
  - beat_cnt is discarded.
- A mem_ready arriving while mem_req=0 is ignored: no ready pulse, no counter change.
- Outputs outside GRANT:
  - mem_addr=0, port_rdata=0.
  - grant_valid=0, grant_id=0.
  - Zero values avoid X propagation into the memory model.
- Non-owner requests wait. Their port_ready stays 0 no matter how long the lock is held.

## Timing
- Reset (async, immediate):
  - State goes to IDLE; owner=0, beat_cnt=0, rr_ptr=0.
  - All outputs are 0: mem_req, mem_addr, port_rdata, port_ready, grant_valid, grant_id.
- Arbitration latency:
  - A request first seen in IDLE at edge N produces mem_req=1 in cycle N+1.
  - With an always-ready memory, the first port_ready is in cycle N+1.
- mem_ready to port_ready and mem_rdata to port_rdata are purely combinational, with zero added latency.
- Consecutive beats of one owner have no bubble. The cache issues its next address in the cycle after ready, and the arbiter stays in GRANT.
- Release always costs one IDLE cycle before the next grant. This applies even when another port is already requesting.
- Release and a new request arriving on the same edge: the new request is arbitrated in the following IDLE cycle, using the updated rr_ptr.
- rst asserted mid-fill: the fill is lost and the cache is responsible for retrying. After rst deasserts, arbitration resumes from port 0.
- Only the currently active beat's state is kept. There is no outstanding-request buffering.

## Test plan
- Single port, zero-wait memory:
  - Stimulus: port 0 requests addresses 0x100, 0x104, 0x108, 0x10C.
  - Required: mem_req rises 1 cycle after port_req; four consecutive port_ready[0] pulses carry the memory words.
  - Required after the fourth pulse: grant_valid=0 for one cycle, rr_ptr=1.
- Simultaneous requests from reset:
  - Stimulus: ports 0 and 1 both request.
  - Required: port 0 is served 4 beats, then 1 idle cycle, then port 1 4 beats.
  - Required: port_ready[1] never asserts during port 0's fill.
- Round-robin fairness:
  - Stimulus: ports 0 and 1 request continuously for 4 lines.
  - Required: grant_id sequence is 0,1,0,1.
- Wait-state memory:
  - Stimulus: mem_ready asserts 3 cycles after each mem_req.
  - Required: port_ready and port_rdata are valid only on those cycles; beat_cnt advances only on them.
- Abandon:
  - Stimulus: owner drops port_req after 2 beats.
  - Required: next cycle IDLE, mem_req=0, rr_ptr advanced.
  - Required: the other requester is granted the cycle after that.
- Reset mid-fill:
  - Stimulus: assert rst during beat 2 of port 1's fill.
  - Required: all outputs 0 immediately.
  - Required: after release with both ports requesting, port 0 is granted first.
